// File: rtl/astro_rom_arbiter.sv
// Shared BIOS/cart ROM RAM arbiter: CPU reads on cpu_ce slots beat buffered HPS download writes.
// Optional ASTRO_CART_MIRROR_EN: out-of-range cart reads mirror the image instead of returning FILL.
module astro_rom_arbiter #(
    parameter int          AW   = 13,
    parameter logic [7:0]  FILL = 8'hFF
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          cpu_ce,
    input  logic          ioctl_download,
    input  logic [7:0]    ioctl_index,
    input  logic [24:0]   ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    input  logic          ioctl_wr,
    output logic          ioctl_wait,
    input  logic [AW-1:0] bios_addr,
    input  logic          bios_rd_n,
    input  logic [AW-1:0] cart_addr,
    input  logic          cart_rd_n,
    output logic [7:0]    bios_do,
    output logic [7:0]    cart_do,
    output logic [AW:0]   mem_addr,
    output logic [7:0]    mem_din,
    output logic          mem_we,
    input  logic [7:0]    mem_q,
    output logic [AW:0]   cart_size,
    output logic          wr_overrun
);

    typedef enum logic {S_IDLE, S_RD_LAT} state_t;

    state_t          state_q, state_d;
    logic            buf_full_q, buf_full_d;
    logic            buf_sel_q, buf_sel_d;
    logic [AW-1:0]   buf_addr_q, buf_addr_d;
    logic [7:0]      buf_data_q, buf_data_d;
    logic            rd_sel_q, rd_sel_d;
    logic            rd_fill_q, rd_fill_d;
    logic [7:0]      bios_do_q, bios_do_d;
    logic [7:0]      cart_do_q, cart_do_d;
    logic [AW:0]     cart_size_q, cart_size_d;
    logic            overrun_q, overrun_d;
    logic            dl_q, dl_d;

    logic            wr_valid;
    logic            rd_req;
    logic            cart_hit;
    logic [AW-1:0]   cart_eff;
    logic [AW:0]     buf_end;

    assign wr_valid = ioctl_wr && (ioctl_index == 8'd0 || ioctl_index == 8'd1)
                      && (ioctl_addr[24:AW] == '0);
    assign rd_req   = !reset && (state_q == S_IDLE) && cpu_ce && (!bios_rd_n || !cart_rd_n);
    assign buf_end  = {1'b0, buf_addr_q} + {{AW{1'b0}}, 1'b1};

`ifdef ASTRO_CART_MIRROR_EN
    logic [AW-1:0] size_m1;
    logic [AW-1:0] mirror_mask;

    assign size_m1 = AW'(cart_size_q - {{AW{1'b0}}, 1'b1});

    // Mask = next power of two minus one, never below 2K.
    for (genvar gi = 0; gi < AW; gi++) begin : g_mask
        assign mirror_mask[gi] = (|size_m1[AW-1:gi]) | (gi < 11);
    end

    assign cart_eff = cart_addr & mirror_mask;
    assign cart_hit = (cart_size_q != '0);
`else
    assign cart_eff = cart_addr;
    assign cart_hit = ({1'b0, cart_addr} < cart_size_q);
`endif

    always_comb begin
        state_d     = state_q;
        buf_full_d  = buf_full_q;
        buf_sel_d   = buf_sel_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        rd_sel_d    = rd_sel_q;
        rd_fill_d   = rd_fill_q;
        bios_do_d   = bios_do_q;
        cart_do_d   = cart_do_q;
        cart_size_d = cart_size_q;
        overrun_d   = overrun_q;
        dl_d        = ioctl_download;
        mem_addr    = {buf_sel_q, buf_addr_q};
        mem_din     = buf_data_q;
        mem_we      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rd_req) begin
                    state_d = S_RD_LAT;
                    if (!bios_rd_n) begin
                        rd_sel_d  = 1'b0;
                        rd_fill_d = 1'b0;
                        mem_addr  = {1'b0, bios_addr};
                    end else begin
                        rd_sel_d  = 1'b1;
                        rd_fill_d = !cart_hit;
                        if (cart_hit) begin
                            mem_addr = {1'b1, cart_eff};
                        end
                    end
                end else if (buf_full_q) begin
                    mem_we     = 1'b1;
                    buf_full_d = 1'b0;
                    if (buf_sel_q && (buf_end > cart_size_q)) begin
                        cart_size_d = buf_end;
                    end
                end
            end
            S_RD_LAT: begin
                state_d = S_IDLE;
                if (rd_sel_q) begin
                    cart_do_d = rd_fill_q ? FILL : mem_q;
                end else begin
                    bios_do_d = mem_q;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Buffer loads only while empty, so it never collides with the issue path above.
        if (ioctl_wr) begin
            if (buf_full_q) begin
                overrun_d = 1'b1;
            end else if (wr_valid) begin
                buf_full_d = 1'b1;
                buf_sel_d  = ioctl_index[0];
                buf_addr_d = ioctl_addr[AW-1:0];
                buf_data_d = ioctl_dout;
            end
        end

        if (ioctl_download && !dl_q && ioctl_index == 8'd1) begin
            cart_size_d = '0;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            buf_full_q  <= 1'b0;
            buf_sel_q   <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
            rd_sel_q    <= 1'b0;
            rd_fill_q   <= 1'b0;
            bios_do_q   <= FILL;
            cart_do_q   <= FILL;
            cart_size_q <= '0;
            overrun_q   <= 1'b0;
            dl_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_full_q  <= buf_full_d;
            buf_sel_q   <= buf_sel_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            rd_sel_q    <= rd_sel_d;
            rd_fill_q   <= rd_fill_d;
            bios_do_q   <= bios_do_d;
            cart_do_q   <= cart_do_d;
            cart_size_q <= cart_size_d;
            overrun_q   <= overrun_d;
            dl_q        <= dl_d;
        end
    end

    assign ioctl_wait = buf_full_q;
    assign bios_do    = bios_do_q;
    assign cart_do    = cart_do_q;
    assign cart_size  = cart_size_q;
    assign wr_overrun = overrun_q;

endmodule

// File: tb/tb_astro_rom_arbiter.sv
// Directed bench for astro_rom_arbiter with a behavioural RAM and a read-result scoreboard.
module tb_astro_rom_arbiter;

    localparam int         AW   = 13;
    localparam logic [7:0] FILL = 8'hFF;

    logic          clk_sys = 1'b0;
    logic          reset;
    logic          cpu_ce;
    logic          ioctl_download;
    logic [7:0]    ioctl_index;
    logic [24:0]   ioctl_addr;
    logic [7:0]    ioctl_dout;
    logic          ioctl_wr;
    logic          ioctl_wait;
    logic [AW-1:0] bios_addr;
    logic          bios_rd_n;
    logic [AW-1:0] cart_addr;
    logic          cart_rd_n;
    logic [7:0]    bios_do;
    logic [7:0]    cart_do;
    logic [AW:0]   mem_addr;
    logic [7:0]    mem_din;
    logic          mem_we;
    logic [7:0]    mem_q;
    logic [AW:0]   cart_size;
    logic          wr_overrun;

    logic [7:0] ram [0:(1<<(AW+1))-1];

    typedef struct {
        bit         is_cart;
        logic [7:0] val;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fails  = 0;
    int   we_count = 0;

    astro_rom_arbiter #(.AW(AW), .FILL(FILL)) dut (
        .clk_sys(clk_sys), .reset(reset), .cpu_ce(cpu_ce),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr),
        .ioctl_wait(ioctl_wait), .bios_addr(bios_addr), .bios_rd_n(bios_rd_n),
        .cart_addr(cart_addr), .cart_rd_n(cart_rd_n), .bios_do(bios_do),
        .cart_do(cart_do), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_we(mem_we), .mem_q(mem_q), .cart_size(cart_size),
        .wr_overrun(wr_overrun)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_din;
            we_count      <= we_count + 1;
        end
        mem_q <= ram[mem_addr];
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: observed no finish, expected finish before 2ms");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] cb(input int a);
        logic [7:0] v;
        v = a[7:0];
        return v ^ 8'h5A;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic hps_write(input logic [7:0] idx, input logic [24:0] a,
                             input logic [7:0] d, input bit expect_wait);
        int n;
        ioctl_index = idx;
        ioctl_addr  = a;
        ioctl_dout  = d;
        ioctl_wr    = 1'b1;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        if (expect_wait) begin
            check("wait_rise", {15'd0, ioctl_wait}, 16'd1);
            n = 0;
            while (ioctl_wait && n < 16) begin
                @(negedge clk_sys);
                n++;
            end
            check("wait_fall", {15'd0, ioctl_wait}, 16'd0);
        end else begin
            check("wait_none", {15'd0, ioctl_wait}, 16'd0);
        end
    endtask

    task automatic sb_pop();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_empty", 16'd1, 16'd0);
        end else begin
            e = sb.pop_front();
            if (e.is_cart) check(e.tag, {8'd0, cart_do}, {8'd0, e.val});
            else           check(e.tag, {8'd0, bios_do}, {8'd0, e.val});
            $display("read %s: bios_do=%h cart_do=%h expected %h", e.tag, bios_do, cart_do, e.val);
        end
    endtask

    task automatic cpu_read(input bit is_cart, input logic [AW-1:0] a,
                            input logic [7:0] exp, input string tag);
        sb.push_back('{is_cart, exp, tag});
        cpu_ce = 1'b1;
        if (is_cart) begin
            cart_addr = a;
            cart_rd_n = 1'b0;
        end else begin
            bios_addr = a;
            bios_rd_n = 1'b0;
        end
        @(negedge clk_sys);
        cpu_ce    = 1'b0;
        bios_rd_n = 1'b1;
        cart_rd_n = 1'b1;
        @(negedge clk_sys);
        sb_pop();
    endtask

    initial begin
        logic [7:0] bios_pat [4];
        int         we0;
        logic [7:0] exp_hi;
        logic [7:0] exp_edge;
        logic [7:0] exp_small;

        for (int i = 0; i < (1 << (AW + 1)); i++) ram[i] = 8'h00;
        bios_pat = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};

        reset = 1'b1; cpu_ce = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'd0;
        ioctl_addr = '0; ioctl_dout = 8'd0; ioctl_wr = 1'b0;
        bios_addr = '0; bios_rd_n = 1'b1; cart_addr = '0; cart_rd_n = 1'b1;
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
        check("rst_wait", {15'd0, ioctl_wait}, 16'd0);
        check("rst_we", {15'd0, mem_we}, 16'd0);
        check("rst_addr", 16'(mem_addr), 16'd0);
        check("rst_bios_do", {8'd0, bios_do}, {8'd0, FILL});
        check("rst_cart_do", {8'd0, cart_do}, {8'd0, FILL});
        check("rst_cart_size", 16'(cart_size), 16'd0);
        check("rst_overrun", {15'd0, wr_overrun}, 16'd0);

        // BIOS load, each write gated by ioctl_wait.
        for (int i = 0; i < 4; i++) hps_write(8'd0, 25'(i), bios_pat[i], 1'b1);
        check("bios_we_count", 16'(we_count), 16'd4);
        for (int i = 0; i < 4; i++) cpu_read(1'b0, AW'(i), bios_pat[i], "bios_rd");

        // Write coincident with a CPU read: read first, write after RD_LAT.
        ioctl_index = 8'd0; ioctl_addr = 25'd4; ioctl_dout = 8'hB4; ioctl_wr = 1'b1;
        sb.push_back('{1'b0, 8'hA1, "co_bios_do"});
        cpu_ce = 1'b1; bios_addr = AW'(1); bios_rd_n = 1'b0;
        #1;
        check("co_rd_addr", 16'(mem_addr), 16'd1);
        check("co_rd_we", {15'd0, mem_we}, 16'd0);
        @(negedge clk_sys);
        ioctl_wr = 1'b0; cpu_ce = 1'b0; bios_rd_n = 1'b1;
        check("co_wait1", {15'd0, ioctl_wait}, 16'd1);
        check("co_we1", {15'd0, mem_we}, 16'd0);
        @(negedge clk_sys);
        check("co_wait2", {15'd0, ioctl_wait}, 16'd1);
        check("co_we2", {15'd0, mem_we}, 16'd1);
        check("co_wr_addr", 16'(mem_addr), 16'd4);
        check("co_wr_din", {8'd0, mem_din}, 16'h00B4);
        sb_pop();
        @(negedge clk_sys);
        check("co_wait3", {15'd0, ioctl_wait}, 16'd0);
        check("co_we3", {15'd0, mem_we}, 16'd0);
        cpu_read(1'b0, AW'(4), 8'hB4, "co_bios4");

        // Overrun: second write while the buffer is still full.
        ioctl_index = 8'd0; ioctl_addr = 25'd5; ioctl_dout = 8'hC5; ioctl_wr = 1'b1;
        @(negedge clk_sys);
        check("ovr_wait", {15'd0, ioctl_wait}, 16'd1);
        ioctl_addr = 25'd6; ioctl_dout = 8'hC6;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        check("ovr_flag", {15'd0, wr_overrun}, 16'd1);
        repeat (2) @(negedge clk_sys);
        cpu_read(1'b0, AW'(5), 8'hC5, "ovr_kept");
        cpu_read(1'b0, AW'(6), 8'h00, "ovr_dropped");
        check("ovr_sticky", {15'd0, wr_overrun}, 16'd1);

        // Discarded writes: bad index, address beyond the image.
        hps_write(8'd2, 25'd7, 8'h77, 1'b0);
        hps_write(8'd0, 25'h2000, 8'h88, 1'b0);
        cpu_read(1'b0, AW'(7), 8'h00, "drop_idx");
        cpu_read(1'b0, AW'(0), 8'hA0, "drop_range");

        // No cart loaded.
        cpu_read(1'b1, AW'(0), FILL, "cart_empty");

        // Cart load of 0x1000 bytes.
        ioctl_index = 8'd1;
        @(negedge clk_sys);
        ioctl_download = 1'b1;
        for (int a = 0; a < 'h1000; a++) begin
            hps_write(8'd1, 25'(a), cb(a), 1'b1);
            if (a == 0) check("cart_size_1", 16'(cart_size), 16'd1);
        end
        ioctl_download = 1'b0;
        check("cart_size_full", 16'(cart_size), 16'h1000);
        cpu_read(1'b1, AW'('h0005), cb('h0005), "cart_5");
        cpu_read(1'b1, AW'('h0FFF), cb('h0FFF), "cart_fff");
`ifdef ASTRO_CART_MIRROR_EN
        exp_hi   = cb('h0005);
        exp_edge = cb('h0000);
`else
        exp_hi   = FILL;
        exp_edge = FILL;
`endif
        cpu_read(1'b1, AW'('h1005), exp_hi, "cart_1005");
        cpu_read(1'b1, AW'('h1000), exp_edge, "cart_1000");
        cpu_read(1'b0, AW'(0), 8'hA0, "bios_intact");

        // New download clears cart_size; one byte at 0x10 -> size 0x11.
        ioctl_index = 8'd1;
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        check("dl_clear", 16'(cart_size), 16'd0);
        hps_write(8'd1, 25'h10, 8'h3C, 1'b1);
        ioctl_download = 1'b0;
        check("cart_size_11", 16'(cart_size), 16'h0011);
`ifdef ASTRO_CART_MIRROR_EN
        exp_small = cb('h0011);
`else
        exp_small = FILL;
`endif
        cpu_read(1'b1, AW'('h0011), exp_small, "cart_past_end");
        cpu_read(1'b1, AW'('h0010), 8'h3C, "cart_last");

        // Reset while the buffer is full and a cart read sits in RD_LAT.
        ioctl_index = 8'd0; ioctl_addr = 25'd8; ioctl_dout = 8'h99; ioctl_wr = 1'b1;
        cpu_ce = 1'b1; cart_addr = AW'('h0010); cart_rd_n = 1'b0;
        @(negedge clk_sys);
        ioctl_wr = 1'b0; cpu_ce = 1'b0; cart_rd_n = 1'b1;
        check("pre_rst_wait", {15'd0, ioctl_wait}, 16'd1);
        we0 = we_count;
        reset = 1'b1;
        #1;
        check("mid_rst_wait", {15'd0, ioctl_wait}, 16'd0);
        check("mid_rst_we", {15'd0, mem_we}, 16'd0);
        check("mid_rst_cart_do", {8'd0, cart_do}, {8'd0, FILL});
        check("mid_rst_size", 16'(cart_size), 16'd0);
        check("mid_rst_overrun", {15'd0, wr_overrun}, 16'd0);
        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
        repeat (4) @(negedge clk_sys);
        check("post_rst_no_we", 16'(we_count), 16'(we0));
        check("post_rst_cart_do", {8'd0, cart_do}, {8'd0, FILL});
        cpu_read(1'b0, AW'(8), 8'h00, "rst_discarded");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
